uart_rx_fifo: RTL and testbench

- 8N1 UART receiver with a first-word-fall-through byte FIFO. It sits between the board `serial_rxd` pin and the BSV top-level, which consumes bytes through a BSV-style get method (`RDY_get`/`EN_get`).
- Oversamples the line on the single system clock (on-chip HFOSC) and reports sticky framing and overrun errors.

---
 rtl/uart_rx_fifo.sv | 130 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Sticky framing/overrun flags; bytes leave through a get/RDY_get/EN_get handshake.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 208,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          serial_rxd,
   output logic [7:0]                    get,
   output logic                          RDY_get,
   input  logic                          EN_get,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          framing_err,
   output logic                          overrun_err,
   input  logic                          EN_clear_err
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_END = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

   state_t          state_q;
   logic [BW-1:0]   baud_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            push_q;
   logic            framing_q;
   logic            rxd_meta_q, rxd_s_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   count_q;
   logic            overrun_q;
   logic            pop, wr_ok;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= serial_rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= WAIT_IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         push_q    <= 1'b0;
         framing_q <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (EN_clear_err) framing_q <= 1'b0;
         case (state_q)
            WAIT_IDLE: begin
               baud_q <= '0;
               if (rxd_s_q) state_q <= IDLE;
            end
            IDLE: begin
               baud_q <= '0;
               if (!rxd_s_q) state_q <= START;
            end
            START: begin
               if (baud_q == HALF_END) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= rxd_s_q ? IDLE : DATA;
               end else baud_q <= baud_q + BW'(1);
            end
            DATA: begin
               if (baud_q == BIT_END) begin
                  baud_q         <= '0;
                  shift_q[bit_q] <= rxd_s_q;
                  bit_q          <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= STOP;
               end else baud_q <= baud_q + BW'(1);
            end
            STOP: begin
               if (baud_q == BIT_END) begin
                  baud_q <= '0;
                  if (rxd_s_q) begin
                     push_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     framing_q <= 1'b1;
                     state_q   <= WAIT_IDLE;
                  end
               end else baud_q <= baud_q + BW'(1);
            end
            default: state_q <= WAIT_IDLE;
         endcase
      end
   end

   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign pop   = EN_get && RDY_get;
   assign wr_ok = push_q && (count_q != FULL || pop);

   always_ff @(posedge CLK) begin
      if (wr_ok) mem_q[wr_q] <= shift_q;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_q      <= '0;
         rd_q      <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_ok) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_q + AW'(1);
         count_q <= count_q + CW'(wr_ok) - CW'(pop);
         if (EN_clear_err) overrun_q <= 1'b0;
         if (push_q && !wr_ok) overrun_q <= 1'b1;
      end
   end

   assign RDY_get     = count_q != '0;
   assign get         = RDY_get ? mem_q[rd_q] : 8'h00;
   assign count       = count_q;
   assign framing_err = framing_q;
   assign overrun_err = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios for uart_rx_fifo at 16 clocks/bit, 4-entry FIFO.
module tb_uart_rx_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       serial_rxd = 1'b1;
   logic [7:0] get;
   logic       rdy_get;
   logic       en_get = 1'b0;
   logic [2:0] count;
   logic       framing_err, overrun_err;
   logic       en_clear_err = 1'b0;
   int         total = 0;
   int         bad = 0;

   uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
      .CLK(clk), .RST_N(rst_n), .serial_rxd(serial_rxd), .get(get), .RDY_get(rdy_get),
      .EN_get(en_get), .count(count), .framing_err(framing_err), .overrun_err(overrun_err),
      .EN_clear_err(en_clear_err)
   );

   always #5 clk = ~clk;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         serial_rxd = 1'b1;
      end
   endtask

   // 160 clocks: start, 8 data LSB first, stop; en_get pulses at clock pop_at of the frame
   task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at);
      for (int i = 0; i < 160; i++) begin
         int k;
         k = i / 16;
         @(negedge clk);
         serial_rxd = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
         en_get = (i == pop_at);
      end
   endtask

   task automatic pop_one();
      @(negedge clk);
      en_get = 1'b1;
      @(negedge clk);
      en_get = 1'b0;
   endtask

   task automatic clear_err();
      @(negedge clk);
      en_clear_err = 1'b1;
      @(negedge clk);
      en_clear_err = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(4);
      rst_n = 1'b1;
      idle(4);
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (rdy_get !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", rdy_get); end
      total++; if (get !== 8'h00) begin bad++; $display("FAIL reset_get got=%h exp=00", get); end
      total++; if ({framing_err, overrun_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {framing_err, overrun_err}); end
   endtask

   task automatic test_single();
      send_frame(8'hA5, 1'b1, -1);
      idle(4);
      total++; if (rdy_get !== 1'b1) begin bad++; $display("FAIL single_rdy got=%b exp=1", rdy_get); end
      total++; if (get !== 8'hA5) begin bad++; $display("FAIL single_get got=%h exp=a5", get); end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
      pop_one();
      total++; if (rdy_get !== 1'b0) begin bad++; $display("FAIL single_pop_rdy got=%b exp=0", rdy_get); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", count); end
      total++; if ({framing_err, overrun_err} !== 2'b00) begin bad++; $display("FAIL single_flags got=%b exp=00", {framing_err, overrun_err}); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v [4] = '{8'h00, 8'hFF, 8'h55, 8'h3C};
      for (int i = 0; i < 4; i++) send_frame(v[i], 1'b1, -1);
      idle(4);
      total++; if (count !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", count); end
      for (int i = 0; i < 4; i++) begin
         total++; if (rdy_get !== 1'b1) begin bad++; $display("FAIL b2b_rdy%0d got=%b exp=1", i, rdy_get); end
         total++; if (get !== v[i]) begin bad++; $display("FAIL b2b_get%0d got=%h exp=%h", i, get, v[i]); end
         pop_one();
      end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", count); end
   endtask

   task automatic test_overrun();
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1);
      idle(4);
      total++; if (count !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d exp=4", count); end
      total++; if (overrun_err !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun_err); end
      for (int i = 1; i <= 4; i++) begin
         total++; if (get !== 8'(i)) begin bad++; $display("FAIL ovr_get%0d got=%h exp=%h", i, get, 8'(i)); end
         pop_one();
      end
      total++; if (rdy_get !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b exp=0", rdy_get); end
      clear_err();
      total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun_err); end
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, -1);
      // push edge is clock 155 of the frame: 2 sync + 8 half-bit + 144 bit + 1
      send_frame(8'h14, 1'b1, 155);
      idle(4);
      total++; if (count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d exp=4", count); end
      total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL fullpop_ovr got=%b exp=0", overrun_err); end
      for (int i = 1; i <= 4; i++) begin
         total++; if (get !== 8'h10 + 8'(i)) begin bad++; $display("FAIL fullpop_get%0d got=%h exp=%h", i, get, 8'h10 + 8'(i)); end
         pop_one();
      end
   endtask

   task automatic test_framing();
      send_frame(8'h81, 1'b0, -1);
      idle(20);
      total++; if (framing_err !== 1'b1) begin bad++; $display("FAIL frm_flag got=%b exp=1", framing_err); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL frm_count got=%0d exp=0", count); end
      send_frame(8'h42, 1'b1, -1);
      idle(4);
      total++; if (count !== 3'd1) begin bad++; $display("FAIL frm_next_count got=%0d exp=1", count); end
      total++; if (get !== 8'h42) begin bad++; $display("FAIL frm_next_get got=%h exp=42", get); end
      pop_one();
   endtask

   task automatic test_reset_mid_data();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         serial_rxd = (i < 16) ? 1'b0 : i[4];
      end
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(40);
      total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
      total++; if ({framing_err, overrun_err} !== 2'b00) begin bad++; $display("FAIL midrst_flags got=%b exp=00", {framing_err, overrun_err}); end
      send_frame(8'h3C, 1'b1, -1);
      idle(4);
      total++; if (get !== 8'h3C || count !== 3'd1) begin bad++; $display("FAIL midrst_next got=%h/%0d exp=3c/1", get, count); end
      pop_one();
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         serial_rxd = 1'b0;
      end
      idle(200);
      total++; if (count !== 3'd0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", count); end
      total++; if ({framing_err, overrun_err} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%b exp=00", {framing_err, overrun_err}); end
      send_frame(8'hC3, 1'b1, -1);
      idle(4);
      total++; if (get !== 8'hC3) begin bad++; $display("FAIL glitch_next got=%h exp=c3", get); end
      pop_one();
   endtask

   task automatic test_reset_line_low();
      @(negedge clk);
      serial_rxd = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (400) @(negedge clk);
      total++; if (count !== 3'd0) begin bad++; $display("FAIL lowrst_count got=%0d exp=0", count); end
      idle(20);
      clear_err();
      send_frame(8'h99, 1'b1, -1);
      idle(4);
      total++; if (count !== 3'd1) begin bad++; $display("FAIL lowrst_next_count got=%0d exp=1", count); end
      total++; if (get !== 8'h99) begin bad++; $display("FAIL lowrst_next_get got=%h exp=99", get); end
      total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL lowrst_frm got=%b exp=0", framing_err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_full_pop();
      test_framing();
      test_reset_mid_data();
      test_glitch();
      test_reset_line_low();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
